i2c_master: RTL and testbench

//  Single-master I2C controller that runs one 7-bit-address, single-byte transfer per start request.
//  It generates SCL and START/STOP conditions and serialises the address+R/W byte. Writes send `data`;

---
 rtl/i2c_master.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_master.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// i2c_master
//   Single-master I2C controller. A rising edge on `start` while idle runs one
//   transfer: START, 7-bit address + R/W, address ACK, one data byte (written
//   from `data` or read into `rdata`), ACK/NACK, STOP. SCL is push-pull; SDA is
//   open-drain (the master only ever drives 0 or releases the line).
//
//   Every bit is four quarter phases of QUARTER clocks each:
//     q0 SCL low, SDA updated | q1 SCL rises | q2 SCL high, SDA sampled | q3 SCL falls
//
// Ports
//   clk      system clock
//   reset    asynchronous, active-high reset
//   start    transfer request, acted on at its rising edge while idle
//   addr     7-bit slave address (latched at the start edge)
//   data     write byte (latched at the start edge)
//   rw       0 = write, 1 = read (latched at the start edge)
//   SCL      bus clock, driven push-pull
//   SDA      bus data, open-drain
//   rdata    byte received by the last completed read
//   busy     high from the start edge until the end of STOP
//   done     one-clock pulse when STOP completes
//   ack_err  slave NACKed the address or the write byte; cleared on next start
// -----------------------------------------------------------------------------
module i2c_master #(
    parameter int QUARTER = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       rw,
    output logic       SCL,
    inout  wire        SDA,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int TW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_READ,
        ST_WACK,
        ST_MNACK,
        ST_STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;     // transmit byte (MSB on the wire) or receive byte
    logic [7:0]    data_q;
    logic          rw_q;
    logic          start_q;
    logic          sda_oe;    // 1 = pull SDA low
    logic          sda_bit;
    logic          q_end;

    assign SDA   = sda_oe ? 1'b0 : 1'bz;
    assign q_end = (tick == TW'(QUARTER - 1));

    // A released line may read as Z or X in simulation; anything that is not
    // a solid 0 counts as 1, so the X/Z case falls through to the else branch.
    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        if (SDA == 1'b0) sda_bit = 1'b0;
        else             sda_bit = 1'b1;
    end

    // Bus levels as a function of where we are in the frame. START and STOP
    // are the only places SDA moves while SCL is high.
    function automatic logic scl_level(input state_t st, input logic [1:0] ph);
        case (st)
            ST_IDLE:  return 1'b1;
            ST_START: return ph != 2'd3;
            ST_STOP:  return ph != 2'd0;
            default:  return (ph == 2'd1) || (ph == 2'd2);
        endcase
    endfunction

    function automatic logic sda_pull(input state_t st, input logic [1:0] ph,
                                      input logic txbit);
        case (st)
            ST_START:          return ph != 2'd0;
            ST_STOP:           return ph != 2'd3;
            ST_ADDR, ST_WRITE: return !txbit;
            default:           return 1'b0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tick    <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            start_q <= 1'b0;
            SCL     <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
        end else begin
            start_q <= start;
            done    <= 1'b0;

            // Pins follow the current state/phase one clock later. SCL and SDA
            // share that lag, so their relative ordering is preserved and the
            // pins come straight from flops.
            SCL    <= scl_level(state, phase);
            sda_oe <= sda_pull(state, phase, shift[7]);

            if (state == ST_IDLE) begin
                tick  <= '0;
                phase <= '0;
                if (start && !start_q) begin
                    state   <= ST_START;
                    busy    <= 1'b1;
                    ack_err <= 1'b0;
                    shift   <= {addr, rw};
                    data_q  <= data;
                    rw_q    <= rw;
                    bit_cnt <= '0;
                end
            end else if (!q_end) begin
                tick <= tick + 1'b1;
            end else begin
                tick  <= '0;
                phase <= phase + 2'd1;

                // End of q2: SCL has been high for a full quarter, sample SDA.
                if (phase == 2'd2) begin
                    case (state)
                        ST_ADDR_ACK, ST_WACK: begin
                            if (sda_bit) ack_err <= 1'b1;
                        end
                        ST_READ: begin
                            shift <= {shift[6:0], sda_bit};
                            if (bit_cnt == 3'd7) rdata <= {shift[6:0], sda_bit};
                        end
                        default: ;
                    endcase
                end

                // End of q3: the bit is over, move on.
                if (phase == 2'd3) begin
                    case (state)
                        ST_START: state <= ST_ADDR;
                        ST_ADDR: begin
                            if (bit_cnt == 3'd7) begin
                                state   <= ST_ADDR_ACK;
                                bit_cnt <= '0;
                                shift   <= data_q;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shift   <= shift << 1;
                            end
                        end
                        ST_ADDR_ACK: begin
                            if (ack_err)   state <= ST_STOP;
                            else if (rw_q) state <= ST_READ;
                            else           state <= ST_WRITE;
                        end
                        ST_WRITE: begin
                            if (bit_cnt == 3'd7) begin
                                state   <= ST_WACK;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shift   <= shift << 1;
                            end
                        end
                        ST_READ: begin
                            if (bit_cnt == 3'd7) begin
                                state   <= ST_MNACK;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        ST_WACK, ST_MNACK: state <= ST_STOP;
                        ST_STOP: begin
                            // Pins already show the idle bus (SCL=1, SDA released).
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_i2c_master
//   Bench for i2c_master with a behavioural I2C slave at address 0x03 on the
//   bus. The slave records every byte it sees the master put on the wire; the
//   transfer task pushes the bytes it expects when it drives a request and
//   pops/compares them once the transfer reports done.
// -----------------------------------------------------------------------------
module tb_i2c_master;

    localparam logic [6:0] SLV_ADDR = 7'h03;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr  = '0;
    logic [7:0] data  = '0;
    logic       rw    = 1'b0;
    wire        scl;
    wire        sda_bus;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;

    logic       slave_pull = 1'b0;

    pullup (sda_bus);
    assign sda_bus = slave_pull ? 1'b0 : 1'bz;

    i2c_master #(.QUARTER(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .addr    (addr),
        .data    (data),
        .rw      (rw),
        .SCL     (scl),
        .SDA     (sda_bus),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    // 8 MHz system clock
    always #62.5 clk = ~clk;

    // ---------------------------------------------------------------- slave --
    typedef enum {S_IDLE, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MACK} smode_t;

    smode_t     smode    = S_IDLE;
    int         sbit     = 0;
    logic [7:0] sh       = '0;
    logic       s_ack    = 1'b0;
    logic       s_rd     = 1'b0;
    logic [7:0] rbyte    = '0;
    logic [7:0] obs_q[$];
    int         starts   = 0;
    int         stops    = 0;
    int         mack_cnt = 0;
    logic       mack_val = 1'b0;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       sda_now;

    always @(scl or sda_bus) begin
        sda_now = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
        if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b1 && sda_now === 1'b0) begin
            starts++;
            smode = S_ADDR;
            sbit = 0;
            sh = '0;
            slave_pull = 1'b0;
        end else if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b0 && sda_now === 1'b1) begin
            stops++;
            smode = S_IDLE;
            slave_pull = 1'b0;
        end else if (scl_prev === 1'b0 && scl === 1'b1) begin
            case (smode)
                S_ADDR: begin
                    sh = {sh[6:0], sda_now};
                    sbit++;
                    if (sbit == 8) begin
                        obs_q.push_back(sh);
                        s_ack = (sh[7:1] == SLV_ADDR);
                        s_rd  = sh[0];
                    end
                end
                S_WDATA: begin
                    sh = {sh[6:0], sda_now};
                    sbit++;
                    if (sbit == 8) obs_q.push_back(sh);
                end
                S_RDATA: sbit++;
                S_MACK: begin
                    mack_val = sda_now;
                    mack_cnt++;
                end
                default: ;
            endcase
        end else if (scl_prev === 1'b1 && scl === 1'b0) begin
            case (smode)
                S_ADDR: begin
                    if (sbit == 8) begin
                        smode = S_AACK;
                        slave_pull = s_ack;
                    end
                end
                S_AACK: begin
                    sbit = 0;
                    sh = '0;
                    if (!s_ack) begin
                        smode = S_IDLE;
                        slave_pull = 1'b0;
                    end else if (s_rd) begin
                        smode = S_RDATA;
                        slave_pull = ~rbyte[7];
                    end else begin
                        smode = S_WDATA;
                        slave_pull = 1'b0;
                    end
                end
                S_WDATA: begin
                    if (sbit == 8) begin
                        smode = S_WACK;
                        slave_pull = 1'b1;
                    end
                end
                S_WACK: begin
                    smode = S_IDLE;
                    slave_pull = 1'b0;
                end
                S_RDATA: begin
                    if (sbit == 8) begin
                        smode = S_MACK;
                        slave_pull = 1'b0;
                    end else begin
                        slave_pull = ~rbyte[7 - sbit];
                    end
                end
                S_MACK: smode = S_IDLE;
                default: ;
            endcase
        end
        scl_prev = scl;
        sda_prev = sda_now;
    end

    // ------------------------------------------------------------ scoreboard --
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rdata = '0;

    // One complete transfer. hold keeps start high afterwards; disturb changes
    // addr/data/rw partway through the address phase.
    task automatic run_xfer(input string tag, input logic [6:0] a, input logic [7:0] d,
                            input logic r, input logic [7:0] rb, input bit hold,
                            input bit disturb);
        bit         present;
        bit         got;
        logic       exp_err;
        logic [7:0] exp_b;
        logic [7:0] obs_b;
        int         s0, p0, m0, busy_seen;

        present = (a == SLV_ADDR);
        exp_err = !present;
        exp_q.push_back({a, r});
        if (present && !r) exp_q.push_back(d);
        if (present && r) exp_rdata = rb;

        s0 = starts;
        p0 = stops;
        m0 = mack_cnt;
        rbyte = rb;
        addr  = a;
        data  = d;
        rw    = r;
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy_rise: got %b want 1", tag, busy);
        end
        total++;
        if (ack_err !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack_err_clear: got %b want 0", tag, ack_err);
        end
        repeat (5) @(negedge clk);
        if (!hold) start = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (disturb && i == 40) begin
                data = 8'hF0;
                addr = 7'h55;
                rw   = ~r;
            end
            if (done === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_done_timeout: got no done in 2000 clks, want done", tag);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: got %b want 0", tag, busy);
        end
        total++;
        if (ack_err !== exp_err) begin
            bad++;
            $display("FAIL %s_ack_err: got %b want %b", tag, ack_err, exp_err);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_width: got %b one clk later, want 0", tag, done);
        end
        total++;
        if (rdata !== exp_rdata) begin
            bad++;
            $display("FAIL %s_rdata: got %02h want %02h", tag, rdata, exp_rdata);
        end
        total++;
        if (starts - s0 != 1) begin
            bad++;
            $display("FAIL %s_start_cond: got %0d want 1", tag, starts - s0);
        end
        total++;
        if (stops - p0 != 1) begin
            bad++;
            $display("FAIL %s_stop_cond: got %0d want 1", tag, stops - p0);
        end
        if (present && r) begin
            total++;
            if (mack_cnt - m0 != 1 || mack_val !== 1'b1) begin
                bad++;
                $display("FAIL %s_master_nack: got cnt=%0d val=%b want cnt=1 val=1",
                         tag, mack_cnt - m0, mack_val);
            end
        end

        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL %s_bus_byte: got nothing want %02h", tag, exp_b);
            end else begin
                obs_b = obs_q.pop_front();
                if (obs_b !== exp_b) begin
                    bad++;
                    $display("FAIL %s_bus_byte: got %02h want %02h", tag, obs_b, exp_b);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL %s_extra_bytes: got %0d want 0", tag, obs_q.size());
            obs_q.delete();
        end

        if (hold) begin
            busy_seen = 0;
            repeat (600) begin
                @(negedge clk);
                if (busy !== 1'b0) busy_seen++;
            end
            total++;
            if (busy_seen != 0 || starts - s0 != 1) begin
                bad++;
                $display("FAIL %s_retrigger: got busy_clks=%0d starts=%0d want 0 and 1",
                         tag, busy_seen, starts - s0);
            end
            start = 1'b0;
        end
        repeat (10) @(negedge clk);
    endtask

    // ----------------------------------------------------------------- tests --
    task automatic test_reset();
        int scl_low, busy_seen;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        exp_rdata = '0;
        total++;
        if (scl !== 1'b1) begin bad++; $display("FAIL reset_scl: got %b want 1", scl); end
        total++;
        if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1 (released)", sda_bus); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (done !== 1'b0 || ack_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got done=%b ack_err=%b want 0 0", done, ack_err);
        end
        total++;
        if (rdata !== exp_rdata) begin bad++; $display("FAIL reset_rdata: got %02h want 00", rdata); end
        reset = 1'b0;
        scl_low   = 0;
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (scl !== 1'b1) scl_low++;
            if (busy !== 1'b0) busy_seen++;
        end
        total++;
        if (scl_low != 0 || busy_seen != 0) begin
            bad++;
            $display("FAIL idle_after_reset: got scl_low=%0d busy=%0d want 0 0", scl_low, busy_seen);
        end
    endtask

    task automatic test_write();
        run_xfer("write", SLV_ADDR, 8'h2F, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_read_held();
        run_xfer("read_held", SLV_ADDR, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0);
    endtask

    task automatic test_addr_nack();
        run_xfer("addr_nack", 7'h55, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer("b2b_w1", SLV_ADDR, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
        run_xfer("b2b_rd", SLV_ADDR, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0);
        run_xfer("b2b_w2", SLV_ADDR, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_addr();
        bit low_seen;
        addr = SLV_ADDR;
        data = 8'h5A;
        rw   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        repeat (62) @(negedge clk);
        // Land the reset while SCL is low inside the address byte.
        low_seen = 1'b0;
        for (int i = 0; i < 40 && !low_seen; i++) begin
            @(negedge clk);
            if (scl === 1'b0 && busy === 1'b1) low_seen = 1'b1;
        end
        total++;
        if (!low_seen) begin
            bad++;
            $display("FAIL mid_addr_reach: got no SCL-low busy cycle in 40 clks, want one");
        end
        #20;
        reset = 1'b1;
        #1;
        exp_rdata = '0;
        total++;
        if (scl !== 1'b1 || sda_bus !== 1'b1) begin
            bad++;
            $display("FAIL mid_addr_reset_bus: got scl=%b sda=%b want 1 1", scl, sda_bus);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_addr_reset_busy: got busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (rdata !== exp_rdata) begin
            bad++;
            $display("FAIL mid_addr_reset_rdata: got %02h want %02h", rdata, exp_rdata);
        end
        repeat (8) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        // The aborted frame never completed; its partial bytes are not expected.
        obs_q.delete();
        run_xfer("after_reset", SLV_ADDR, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_held();
        test_addr_nack();
        test_back_to_back();
        test_reset_mid_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
